// File: rtl/bus_timeout_pkg.sv
// Shared definitions for the bus timeout monitor: state encoding and default timeouts.
package bus_timeout_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      FAIL = 2'd2
   } busState_t;

   localparam int DEFAULT_TIMEOUT_MEM = 64;
   localparam int DEFAULT_TIMEOUT_IO  = 256;

   function automatic int maxOf(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/bus_timeout_timeout_counter.sv
// Loadable down-counter used to time how long a bus cycle waits for its acknowledge.
module timeout_counter #(
   parameter int WIDTH = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] loadValue,
   input  logic             dec,
   output logic [WIDTH-1:0] count,
   output logic             zero
);

   logic [WIDTH-1:0] countReg;

   // Load takes priority; decrement saturates at zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         countReg <= '0;
      end else if (load) begin
         countReg <= loadValue;
      end else if (dec && (countReg != '0)) begin
         countReg <= countReg - 1'b1;
      end
   end

   assign count = countReg;
   assign zero  = (countReg == '0);

endmodule

// File: rtl/bus_timeout.sv
// Watches CPU bus cycles, stalls the CPU while an ACK is outstanding and flags
// non-existent memory/devices when no ACK arrives within the per-type timeout.
module bus_timeout
   import bus_timeout_pkg::*;
#(
   parameter int TIMEOUT_MEM = DEFAULT_TIMEOUT_MEM,
   parameter int TIMEOUT_IO  = DEFAULT_TIMEOUT_IO,
   parameter int CNT_WIDTH   = 9,
   parameter int ADDR_WIDTH  = 36
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  busREQ,
   input  logic                  busIO,
   input  logic [ADDR_WIDTH-1:0] busADDR,
   input  logic                  busACK,
   input  logic                  intrCLR,
   output logic                  memWAIT,
   output logic                  ioWAIT,
   output logic                  ioBUSY,
   output logic                  nxmINTR,
   output logic                  nxdINTR,
   output logic [ADDR_WIDTH-1:0] failADDR,
   output logic                  failVALID
);

   localparam int MAX_LOAD  = maxOf(TIMEOUT_MEM, TIMEOUT_IO) - 1;
   localparam int CNT_LIMIT = 2 ** CNT_WIDTH;

   generate
      if (TIMEOUT_MEM < 1 || TIMEOUT_IO < 1) begin : gBadTimeout
         $error("bus_timeout: TIMEOUT_MEM and TIMEOUT_IO must be at least 1");
      end
      if (MAX_LOAD >= CNT_LIMIT) begin : gBadWidth
         $error("bus_timeout: CNT_WIDTH too small for the largest timeout");
      end
   endgenerate

   localparam logic [CNT_WIDTH-1:0] MEM_LOAD = CNT_WIDTH'(TIMEOUT_MEM - 1);
   localparam logic [CNT_WIDTH-1:0] IO_LOAD  = CNT_WIDTH'(TIMEOUT_IO - 1);

   busState_t             stateReg, stateNext;
   logic                  typeReg;
   logic [ADDR_WIDTH-1:0] addrReg;
   logic                  nxmReg, nxdReg, failValidReg;
   logic [ADDR_WIDTH-1:0] failAddrReg;

   logic                  latchCycle, failSet, cntLoad, cntDec, cntZero;
   logic [CNT_WIDTH-1:0]  cntValue;

   timeout_counter #(
      .WIDTH (CNT_WIDTH)
   ) uCounter (
      .clk       (clk),
      .rst       (rst),
      .load      (cntLoad),
      .loadValue (busIO ? IO_LOAD : MEM_LOAD),
      .dec       (cntDec),
      .count     (cntValue),
      .zero      (cntZero)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         stateReg <= IDLE;
      end else begin
         stateReg <= stateNext;
      end
   end

   // Next state, counter control and the CPU stall outputs.
   always_comb begin
      stateNext  = stateReg;
      latchCycle = 1'b0;
      failSet    = 1'b0;
      cntLoad    = 1'b0;
      cntDec     = 1'b0;
      memWAIT    = 1'b0;
      ioWAIT     = 1'b0;
      case (stateReg)
         IDLE: begin
            if (busREQ && !busACK) begin
               latchCycle = 1'b1;
               cntLoad    = 1'b1;
               stateNext  = WAIT;
               memWAIT    = !busIO;
               ioWAIT     = busIO;
            end
         end
         WAIT: begin
            memWAIT = !busACK && !typeReg;
            ioWAIT  = !busACK && typeReg;
            if (busACK) begin
               stateNext = IDLE;
            end else if (cntZero) begin
               failSet   = 1'b1;
               stateNext = FAIL;
            end else begin
               cntDec = 1'b1;
            end
         end
         FAIL: begin
            stateNext = IDLE;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // A new failure wins over a coincident intrCLR so no timeout is ever lost.
   always_ff @(posedge clk) begin
      if (rst) begin
         typeReg      <= 1'b0;
         addrReg      <= '0;
         nxmReg       <= 1'b0;
         nxdReg       <= 1'b0;
         failValidReg <= 1'b0;
         failAddrReg  <= '0;
      end else begin
         if (latchCycle) begin
            typeReg <= busIO;
            addrReg <= busADDR;
         end
         if (failSet) begin
            failAddrReg  <= addrReg;
            failValidReg <= 1'b1;
            if (typeReg) begin
               nxdReg <= 1'b1;
            end else begin
               nxmReg <= 1'b1;
            end
         end else if (intrCLR) begin
            nxmReg       <= 1'b0;
            nxdReg       <= 1'b0;
            failValidReg <= 1'b0;
         end
      end
   end

   assign ioBUSY    = ((stateReg == WAIT) || (stateReg == FAIL)) && typeReg;
   assign nxmINTR   = nxmReg;
   assign nxdINTR   = nxdReg;
   assign failADDR  = failAddrReg;
   assign failVALID = failValidReg;

endmodule

// File: tb/tb_bus_timeout.sv
// Directed bench for bus_timeout with a scoreboard of expected timeout captures.
module tb_bus_timeout;

   localparam int TM = 4;
   localparam int TI = 6;
   localparam int CW = 3;
   localparam int AW = 36;

   typedef struct {
      logic          io;
      logic [AW-1:0] addr;
   } failExp_t;

   logic          clk = 1'b0;
   logic          rst, busREQ, busIO, busACK, intrCLR;
   logic [AW-1:0] busADDR;
   logic          memWAIT, ioWAIT, ioBUSY, nxmINTR, nxdINTR, failVALID;
   logic [AW-1:0] failADDR;

   int       passCnt  = 0;
   int       failCnt  = 0;
   int       totalCnt = 0;
   failExp_t expQ[$];

   always #5 clk = ~clk;

   bus_timeout #(
      .TIMEOUT_MEM (TM),
      .TIMEOUT_IO  (TI),
      .CNT_WIDTH   (CW),
      .ADDR_WIDTH  (AW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .busREQ    (busREQ),
      .busIO     (busIO),
      .busADDR   (busADDR),
      .busACK    (busACK),
      .intrCLR   (intrCLR),
      .memWAIT   (memWAIT),
      .ioWAIT    (ioWAIT),
      .ioBUSY    (ioBUSY),
      .nxmINTR   (nxmINTR),
      .nxdINTR   (nxdINTR),
      .failADDR  (failADDR),
      .failVALID (failVALID)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      totalCnt++;
      assert (obs === exp) passCnt++;
      else begin
         failCnt++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idleInputs;
      busREQ  = 1'b0;
      busIO   = 1'b0;
      busACK  = 1'b0;
      intrCLR = 1'b0;
      busADDR = '0;
   endtask

   task automatic clearFlags;
      tick; intrCLR = 1'b1;
      tick; intrCLR = 1'b0; #1;
      chk("clr nxm", nxmINTR, 1'b0);
      chk("clr nxd", nxdINTR, 1'b0);
      chk("clr failVALID", failVALID, 1'b0);
   endtask

   // Unacknowledged cycle; a conflicting request is held during WAIT to prove it is ignored.
   task automatic timeoutCycle(input logic io, input logic [AW-1:0] addr,
                               input logic flagBefore, input logic clrAtEntry);
      int       t;
      failExp_t e;
      t = io ? TI : TM;
      tick;
      busREQ = 1'b1; busIO = io; busADDR = addr; busACK = 1'b0;
      expQ.push_back('{io, addr});
      #1;
      chk("req memWAIT", memWAIT, !io);
      chk("req ioWAIT", ioWAIT, io);
      for (int c = 1; c <= t; c++) begin
         tick;
         busREQ = 1'b1; busIO = !io; busADDR = ~addr;
         intrCLR = clrAtEntry && (c == t);
         #1;
         chk("wait memWAIT", memWAIT, !io);
         chk("wait ioWAIT", ioWAIT, io);
         chk("wait ioBUSY", ioBUSY, io);
         chk("wait flag", io ? nxdINTR : nxmINTR, flagBefore);
      end
      tick;
      idleInputs();
      #1;
      chk("fail memWAIT", memWAIT, 1'b0);
      chk("fail ioWAIT", ioWAIT, 1'b0);
      chk("fail ioBUSY", ioBUSY, io);
      chk("fail failVALID", failVALID, 1'b1);
      if (expQ.size() == 0) begin
         totalCnt++;
         failCnt++;
         $error("FAIL scoreboard: observed empty queue expected entry");
      end else begin
         e = expQ.pop_front();
         chk("fail failADDR", failADDR, e.addr);
         chk("fail flag", e.io ? nxdINTR : nxmINTR, 1'b1);
      end
      tick;
      #1;
      chk("post ioBUSY", ioBUSY, 1'b0);
      chk("post memWAIT", memWAIT, 1'b0);
   endtask

   initial begin
      idleInputs();
      rst = 1'b1;
      tick;
      tick;
      rst = 1'b0;
      #1;
      chk("rst memWAIT", memWAIT, 1'b0);
      chk("rst ioWAIT", ioWAIT, 1'b0);
      chk("rst ioBUSY", ioBUSY, 1'b0);
      chk("rst nxm", nxmINTR, 1'b0);
      chk("rst nxd", nxdINTR, 1'b0);
      chk("rst failVALID", failVALID, 1'b0);
      chk("rst failADDR", failADDR, '0);

      // Memory timeout, then clear.
      timeoutCycle(1'b0, 36'h1_2345_6789, 1'b0, 1'b0);
      chk("t1 nxd untouched", nxdINTR, 1'b0);
      clearFlags();

      // IO cycle acknowledged on the third WAIT clock.
      tick; busREQ = 1'b1; busIO = 1'b1; busADDR = 36'h3A0; #1;
      chk("ack req ioWAIT", ioWAIT, 1'b1);
      chk("ack req memWAIT", memWAIT, 1'b0);
      tick; busREQ = 1'b0; #1;
      chk("ack w1 ioWAIT", ioWAIT, 1'b1);
      chk("ack w1 ioBUSY", ioBUSY, 1'b1);
      tick; #1;
      chk("ack w2 ioWAIT", ioWAIT, 1'b1);
      tick; busACK = 1'b1; #1;
      chk("ack w3 ioWAIT", ioWAIT, 1'b0);
      chk("ack w3 ioBUSY", ioBUSY, 1'b1);
      tick; busACK = 1'b0; #1;
      chk("ack idle ioBUSY", ioBUSY, 1'b0);
      chk("ack idle ioWAIT", ioWAIT, 1'b0);
      chk("ack nxd", nxdINTR, 1'b0);

      // Requests acknowledged in the same clock never stall.
      tick; busREQ = 1'b1; busIO = 1'b0; busACK = 1'b1; busADDR = 36'h55; #1;
      chk("same memWAIT", memWAIT, 1'b0);
      tick; busIO = 1'b1; #1;
      chk("same ioWAIT", ioWAIT, 1'b0);
      chk("same ioBUSY", ioBUSY, 1'b0);
      tick; idleInputs(); #1;
      chk("same after ioBUSY", ioBUSY, 1'b0);
      chk("same failVALID", failVALID, 1'b0);

      // IO timeout with intrCLR on the FAIL-entry clock: set wins.
      timeoutCycle(1'b1, 36'hABC, 1'b0, 1'b1);
      clearFlags();

      // Reset in the middle of WAIT at count 2.
      tick; busREQ = 1'b1; busIO = 1'b0; busADDR = 36'h777; #1;
      chk("rstw req memWAIT", memWAIT, 1'b1);
      tick; busREQ = 1'b0; #1;
      tick; rst = 1'b1; #1;
      chk("rstw cnt2 memWAIT", memWAIT, 1'b1);
      tick; rst = 1'b0; #1;
      chk("rstw memWAIT", memWAIT, 1'b0);
      chk("rstw ioBUSY", ioBUSY, 1'b0);
      chk("rstw nxm", nxmINTR, 1'b0);
      chk("rstw failVALID", failVALID, 1'b0);
      chk("rstw failADDR", failADDR, '0);
      tick; #1;
      chk("rstw late nxm", nxmINTR, 1'b0);
      timeoutCycle(1'b0, 36'h9_0000_0001, 1'b0, 1'b0);
      clearFlags();

      // Back-to-back timeouts: newest address wins, both flags stick.
      timeoutCycle(1'b0, 36'h1000, 1'b0, 1'b0);
      timeoutCycle(1'b1, 36'h3A0, 1'b0, 1'b0);
      chk("b2b nxm", nxmINTR, 1'b1);
      chk("b2b nxd", nxdINTR, 1'b1);
      chk("b2b failADDR", failADDR, 36'h3A0);
      chk("b2b queue drained", expQ.size(), 0);

      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
